spi_target: RTL and testbench
=============================

# spi_target

SPI mode-0 target (slave) that terminates an external SPI master arriving on shared GPIO pads. It serves as the responder end of the SoC's SPI master links and supports board-level bring-up, where an external host streams bytes into the SoC. It oversamples `i_sclk`/`i_cs_n`/`i_mosi` on the system clock and exchanges full-duplex bytes with the SoC through valid/ready byte interfaces. Its MISO drive and output enable feed the pad mux, using the same active-low enable convention as the pad enables.

## Interface
- `SYNC_STAGES`, 2: synchronizer depth on `i_sclk`, `i_cs_n`, `i_mosi` (minimum 2).
- `IDLE_BYTE`, 8'hFF: byte shifted out when no TX byte is available.
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous active-low reset.
- `i_sclk`  in  1  SPI clock from pad; idle low.
- `i_cs_n`  in  1  chip select from pad; active low.
- `i_mosi`  in  1  serial data from master.
- `o_miso`  out  1  serial data to master.
- `o_miso_oen`  out  1  pad output enable, active low; 0 only while a frame is active.
- `rx_data`  out  8  received byte.
- `rx_valid`  out  1  `rx_data` valid; held until accepted.
- `rx_ready`  in  1  consumer accepts `rx_data` when it is high together with `rx_valid`.
- `tx_data`  in  8  next byte to send.
- `tx_valid`  in  1  `tx_data` available.
- `tx_ready`  out  1  one-cycle pulse; `tx_data` was consumed this cycle.
- `o_busy`  out  1  frame active.
- `o_frame_end`  out  1  one-cycle pulse on frame termination.
- `o_rx_overrun`  out  1  sticky; a received byte was dropped.
- `o_tx_underrun`  out  1  sticky; `IDLE_BYTE` was sent.
- `o_frame_err`  out  1  sticky; the frame ended with a partial byte.
- `i_clr_status`  in  1  pulse; clears all three sticky flags.

## Operation
- Synchronizers reset to `cs_n=1`, `sclk=0`, `mosi=1`.
- Edge detect compares the last synchronized stage with a delay flop, giving `sclk_rise`, `sclk_fall`, `cs_fall`, and `cs_rise` strobes.
- States:
  - `DISARMED` (after reset): waits until synchronized `cs_n`=1, then goes to `IDLE`. A `cs_n` held low through reset is therefore ignored until it deasserts.
  - `IDLE`: on `cs_fall` → `ACTIVE`. The block clears `bit_cnt`, loads the TX shifter, and sets `o_miso_oen`=0.
  - `ACTIVE`: on `cs_rise` → `IDLE`.
- TX shifter load at frame start and at each byte boundary:
  - If `tx_valid`=1: load `tx_data` and pulse `tx_ready`.
  - Otherwise: load `IDLE_BYTE` and set `o_tx_underrun`.
- `o_miso` = TX shifter bit 7 (MSB first).
- On `sclk_rise` (ACTIVE):
  - `rx_shift <= {rx_shift[6:0], mosi_s}`; `bit_cnt` increments mod 8.
  - When `bit_cnt` was 7, the byte is complete:
    - If `rx_valid`=0, or `rx_ready`=1 in the same cycle: `rx_data <= {rx_shift[6:0], mosi_s}` and `rx_valid <= 1`.
    - Otherwise the new byte is dropped, `rx_data` is unchanged, and `o_rx_overrun` is set.
- On `sclk_fall` (ACTIVE):
  - If `bit_cnt`==0 (a byte boundary): reload the TX shifter as above.
  - Otherwise: shift the TX shifter left by 1.
- On `cs_rise`:
  - Pulse `o_frame_end` and set `o_miso_oen`=1.
  - If `bit_cnt`≠0, set `o_frame_err` and discard the partial byte.
  - The pending `rx_valid` is retained.
- Priority:
  - `cs_rise` beats a coincident `sclk` edge; that edge is ignored.
  - A set event beats `i_clr_status` in the same cycle.
  - `rx_ready` acceptance and a new completed byte in the same cycle causes no overrun.
- Mid-operation `reset_n` low: everything returns to reset values, and the block re-enters `DISARMED`.

## Timing
- Reset values:
  - `o_miso`=1, `o_miso_oen`=1.
  - `rx_data`=0, `rx_valid`=0, `tx_ready`=0.
  - `o_busy`=0, `o_frame_end`=0, all sticky flags 0.
- Strobe latency: SYNC_STAGES+1 clk after the pad edge.
- `rx_valid` asserts 1 clk after the 8th `sclk_rise` strobe, i.e. SYNC_STAGES+2 clk after the pad edge.
- `o_miso` updates 1 clk after the `sclk_fall` strobe, i.e. SYNC_STAGES+2 clk after the pad edge.
- The first bit is valid SYNC_STAGES+2 clk after the `i_cs_n` falling edge.
- Master constraints:
  - SCLK high and low phases ≥ SYNC_STAGES+3 clk each, i.e. f_sclk ≤ f_clk/10 at the default depth.
  - ≥ SYNC_STAGES+3 clk from CS fall to the first SCLK rise.
  - ≥ 2 clk of CS high between frames.
- `o_busy` = state==`ACTIVE`.

## Test plan
- Reset with `i_cs_n`=0 held, release, then clock 8 SCLK → no `rx_valid` and `o_miso_oen`=1. After CS toggles high then low, a frame sending 0xA5 → `rx_data`=0xA5, `rx_valid`=1.
- `tx_valid`=1 with 0x3C then 0xC3 queued, master sends 0x11 and 0x22 in one frame → MISO bits read 0x3C then 0xC3. `tx_ready` pulses twice and `rx_data` sequence is 0x11 then 0x22.
- `tx_valid`=0 throughout one byte → MISO = 0xFF and `o_tx_underrun`=1. `i_clr_status` → flag 0.
- `rx_ready`=0, master sends 0x55 then 0x66 → `rx_data` stays 0x55 and `o_rx_overrun`=1. Then `rx_ready`=1 for 1 clk → `rx_valid`=0.
- CS deasserted after 5 bits → `o_frame_end` pulse, `o_frame_err`=1, no `rx_valid`, `o_miso_oen`=1. The next frame sending 0x81 is received correctly.
- Assert `reset_n` mid-byte → all outputs at reset values within 0 clk (asynchronous). After re-arm, a clean frame sending 0x7E → `rx_data`=0x7E.

Source files
------------

// File: rtl/spi_target.sv
// SPI mode-0 target: oversamples the pad-side SCLK/CS_N/MOSI on clk and swaps bytes
// with the SoC over valid/ready. MISO drive and its active-low enable feed the pad mux.
module spi_target #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_BYTE   = 8'hFF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_sclk,
  input  logic       i_cs_n,
  input  logic       i_mosi,
  output logic       o_miso,
  output logic       o_miso_oen,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       o_busy,
  output logic       o_frame_end,
  output logic       o_rx_overrun,
  output logic       o_tx_underrun,
  output logic       o_frame_err,
  input  logic       i_clr_status
);

  typedef enum logic [1:0] {DISARMED, IDLE, ACTIVE} state_t;

  // Pad bits packed as {sclk, cs_n, mosi}; reset to the bus idle levels.
  localparam logic [2:0] SYNC_RST = 3'b011;
  localparam int         PW       = $clog2(SYNC_STAGES + 1);

  logic [2:0] pad_raw;
  logic [2:0] pad_s;
  logic       sclk_s, cs_s, mosi_s;

  assign pad_raw = {i_sclk, i_cs_n, i_mosi};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sync
      logic [SYNC_STAGES-1:0] chain_reg;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          chain_reg <= {SYNC_STAGES{SYNC_RST[gi]}};
        end else begin
          chain_reg <= {chain_reg[SYNC_STAGES-2:0], pad_raw[gi]};
        end
      end
      assign pad_s[gi] = chain_reg[SYNC_STAGES-1];
    end
  endgenerate

  assign sclk_s = pad_s[2];
  assign cs_s   = pad_s[1];
  assign mosi_s = pad_s[0];

  logic sclk_d_reg, cs_d_reg;
  logic sclk_rise, sclk_fall, cs_fall, cs_rise;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_d_reg <= 1'b0;
      cs_d_reg   <= 1'b1;
    end else begin
      sclk_d_reg <= sclk_s;
      cs_d_reg   <= cs_s;
    end
  end

  assign sclk_rise = sclk_s & ~sclk_d_reg;
  assign sclk_fall = ~sclk_s & sclk_d_reg;
  assign cs_fall   = ~cs_s & cs_d_reg;
  assign cs_rise   = cs_s & ~cs_d_reg;

  // The synchronizer resets to cs_n=1, so DISARMED only trusts cs_s once the
  // chain has been refilled from the pad; a CS held low through reset then stays ignored.
  logic [PW-1:0] prime_cnt_reg;
  logic          primed;

  assign primed = (prime_cnt_reg == PW'(SYNC_STAGES));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prime_cnt_reg <= '0;
    end else if (!primed) begin
      prime_cnt_reg <= prime_cnt_reg + 1'b1;
    end
  end

  state_t state_reg, state_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= DISARMED;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      DISARMED: if (primed && cs_s) state_next = IDLE;
      IDLE:     if (cs_fall)        state_next = ACTIVE;
      ACTIVE:   if (cs_rise)        state_next = IDLE;
      default:                      state_next = DISARMED;
    endcase
  end

  always_comb begin
    o_busy = (state_reg == ACTIVE);
  end

  logic [2:0] bit_cnt_reg;
  logic [7:0] tx_shift_reg, rx_shift_reg, rx_data_reg;
  logic       rx_valid_reg, miso_oen_reg, frame_end_reg;
  logic       rx_overrun_reg, tx_underrun_reg, frame_err_reg;

  logic       frame_start, frame_stop, bit_rise, bit_fall;
  logic       tx_load, byte_done, rx_take, rx_accept;
  logic       overrun_set, underrun_set, frame_err_set;
  logic [7:0] tx_byte, rx_byte;

  // cs_rise wins over a coincident SCLK edge, so both bit strobes are masked by it.
  assign frame_start   = (state_reg == IDLE) && cs_fall;
  assign frame_stop    = (state_reg == ACTIVE) && cs_rise;
  assign bit_rise      = (state_reg == ACTIVE) && !cs_rise && sclk_rise;
  assign bit_fall      = (state_reg == ACTIVE) && !cs_rise && sclk_fall;
  assign tx_load       = frame_start || (bit_fall && (bit_cnt_reg == 3'd0));
  assign tx_byte       = tx_valid ? tx_data : IDLE_BYTE;
  assign rx_byte       = {rx_shift_reg[6:0], mosi_s};
  assign byte_done     = bit_rise && (bit_cnt_reg == 3'd7);
  assign rx_take       = byte_done && (!rx_valid_reg || rx_ready);
  assign rx_accept     = rx_valid_reg && rx_ready;
  assign overrun_set   = byte_done && rx_valid_reg && !rx_ready;
  assign underrun_set  = tx_load && !tx_valid;
  assign frame_err_set = frame_stop && (bit_cnt_reg != 3'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt_reg     <= 3'd0;
      tx_shift_reg    <= 8'hFF;
      rx_shift_reg    <= 8'h00;
      rx_data_reg     <= 8'h00;
      rx_valid_reg    <= 1'b0;
      miso_oen_reg    <= 1'b1;
      frame_end_reg   <= 1'b0;
      rx_overrun_reg  <= 1'b0;
      tx_underrun_reg <= 1'b0;
      frame_err_reg   <= 1'b0;
    end else begin
      frame_end_reg <= frame_stop;

      if (frame_start || frame_stop) begin
        bit_cnt_reg <= 3'd0;
      end else if (bit_rise) begin
        bit_cnt_reg <= bit_cnt_reg + 3'd1;
      end

      if (bit_rise) begin
        rx_shift_reg <= rx_byte;
      end

      if (tx_load) begin
        tx_shift_reg <= tx_byte;
      end else if (bit_fall) begin
        tx_shift_reg <= {tx_shift_reg[6:0], 1'b1};
      end

      if (rx_take) begin
        rx_data_reg  <= rx_byte;
        rx_valid_reg <= 1'b1;
      end else if (rx_accept) begin
        rx_valid_reg <= 1'b0;
      end

      if (frame_start) begin
        miso_oen_reg <= 1'b0;
      end else if (frame_stop) begin
        miso_oen_reg <= 1'b1;
      end

      rx_overrun_reg  <= overrun_set   | (rx_overrun_reg  & ~i_clr_status);
      tx_underrun_reg <= underrun_set  | (tx_underrun_reg & ~i_clr_status);
      frame_err_reg   <= frame_err_set | (frame_err_reg   & ~i_clr_status);
    end
  end

  assign tx_ready      = tx_load && tx_valid;
  assign o_miso        = tx_shift_reg[7];
  assign o_miso_oen    = miso_oen_reg;
  assign rx_data       = rx_data_reg;
  assign rx_valid      = rx_valid_reg;
  assign o_frame_end   = frame_end_reg;
  assign o_rx_overrun  = rx_overrun_reg;
  assign o_tx_underrun = tx_underrun_reg;
  assign o_frame_err   = frame_err_reg;

endmodule

// File: tb/tb_spi_target.sv
// Bench for spi_target: a bit-banged SPI master, a TX byte source and an RX sink,
// checked against frame-level expectations from vector tables and a random model.
module tb_spi_target;

  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       i_sclk = 1'b0;
  logic       i_cs_n = 1'b1;
  logic       i_mosi = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       i_clr_status = 1'b0;

  logic       o_miso, o_miso_oen, rx_valid, tx_ready, o_busy, o_frame_end;
  logic       o_rx_overrun, o_tx_underrun, o_frame_err;
  logic [7:0] rx_data;

  spi_target #(.SYNC_STAGES(2), .IDLE_BYTE(8'hFF)) dut (
    .clk(clk), .reset_n(reset_n), .i_sclk(i_sclk), .i_cs_n(i_cs_n), .i_mosi(i_mosi),
    .o_miso(o_miso), .o_miso_oen(o_miso_oen), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .o_busy(o_busy), .o_frame_end(o_frame_end), .o_rx_overrun(o_rx_overrun),
    .o_tx_underrun(o_tx_underrun), .o_frame_err(o_frame_err), .i_clr_status(i_clr_status)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int tx_pops = 0;
  int fe_cnt = 0;
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] mo_buf[8];
  logic [7:0] mi_buf[8];

  typedef struct {
    int              n;
    logic [0:2][7:0] mo;
    int              ntx;
    logic [0:2][7:0] tx;
    logic [0:2][7:0] miso;
    int              pops;
    logic            underrun;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tx_drive();
    tx_valid = (tx_q.size() > 0);
    tx_data  = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
  endtask

  task automatic clr_pulse();
    i_clr_status = 1'b1;
    clks(1);
    i_clr_status = 1'b0;
  endtask

  // Master samples MISO just before raising SCLK and changes MOSI after lowering it.
  task automatic spi_bits(input logic [7:0] b, input int nb, output logic [7:0] m);
    m = 8'h00;
    for (int i = 7; i > 7 - nb; i--) begin
      i_mosi = b[i];
      clks(HALF);
      m[i] = o_miso;
      i_sclk = 1'b1;
      clks(HALF);
      i_sclk = 1'b0;
    end
  endtask

  task automatic frame(input int n);
    logic [7:0] m;
    i_cs_n = 1'b0;
    for (int b = 0; b < n; b++) begin
      spi_bits(mo_buf[b], 8, m);
      mi_buf[b] = m;
    end
    clks(HALF);
    i_cs_n = 1'b1;
    clks(8);
  endtask

  always @(negedge clk) begin
    if (rx_valid && rx_ready) rx_q.push_back(rx_data);
    if (o_frame_end) fe_cnt++;
  end

  // The byte is consumed at the edge following a tx_ready cycle; advance after it.
  always @(negedge clk) begin
    if (tx_ready) begin
      tx_pops++;
      @(posedge clk);
      #1;
      if (tx_q.size() > 0) void'(tx_q.pop_front());
      tx_drive();
    end
  end

  task automatic run_and_check(input string tag, input vec_t v);
    int pops0, fe0;
    clr_pulse();
    rx_q.delete();
    tx_q.delete();
    for (int k = 0; k < v.ntx; k++) tx_q.push_back(v.tx[k]);
    tx_drive();
    pops0 = tx_pops;
    fe0 = fe_cnt;
    for (int k = 0; k < v.n; k++) mo_buf[k] = v.mo[k];
    frame(v.n);
    chk({tag, " rx_count"}, rx_q.size(), v.n);
    for (int k = 0; k < v.n; k++) begin
      if (k < rx_q.size()) chk({tag, " rx_byte"}, int'(rx_q[k]), int'(v.mo[k]));
      chk({tag, " miso_byte"}, int'(mi_buf[k]), int'(v.miso[k]));
    end
    chk({tag, " tx_pops"}, tx_pops - pops0, v.pops);
    chk({tag, " underrun"}, int'(o_tx_underrun), int'(v.underrun));
    chk({tag, " frame_err"}, int'(o_frame_err), 0);
    chk({tag, " frame_end"}, fe_cnt - fe0, 1);
    chk({tag, " oen_idle"}, int'(o_miso_oen), 1);
    $display("%s: n=%0d ntx=%0d miso0=%h rx=%0d pops=%0d und=%0b", tag, v.n, v.ntx,
             mi_buf[0], rx_q.size(), tx_pops - pops0, o_tx_underrun);
    tx_q.delete();
    tx_drive();
  endtask

  initial begin
    logic [7:0] m;
    int fe0;
    vec_t rv;

    vecs[0] = '{2, {8'h11, 8'h22, 8'h00}, 2, {8'h3C, 8'hC3, 8'h00}, {8'h3C, 8'hC3, 8'h00}, 2, 1'b1};
    vecs[1] = '{1, {8'hA5, 8'h00, 8'h00}, 0, {8'h00, 8'h00, 8'h00}, {8'hFF, 8'h00, 8'h00}, 0, 1'b1};
    vecs[2] = '{1, {8'h81, 8'h00, 8'h00}, 2, {8'h5A, 8'h99, 8'h00}, {8'h5A, 8'h00, 8'h00}, 2, 1'b0};
    vecs[3] = '{3, {8'h00, 8'hFF, 8'h7E}, 1, {8'hF0, 8'h00, 8'h00}, {8'hF0, 8'hFF, 8'hFF}, 1, 1'b1};

    // Reset held with CS low: reset values, then the CS-low period is ignored.
    i_cs_n = 1'b0;
    clks(3);
    chk("rst miso", int'(o_miso), 1);
    chk("rst oen", int'(o_miso_oen), 1);
    chk("rst rx_data", int'(rx_data), 0);
    chk("rst rx_valid", int'(rx_valid), 0);
    chk("rst tx_ready", int'(tx_ready), 0);
    chk("rst busy", int'(o_busy), 0);
    chk("rst frame_end", int'(o_frame_end), 0);
    chk("rst flags", int'({o_rx_overrun, o_tx_underrun, o_frame_err}), 0);
    reset_n = 1'b1;
    clks(6);
    spi_bits(8'hA5, 8, m);
    clks(6);
    chk("disarmed rx_valid", int'(rx_valid), 0);
    chk("disarmed oen", int'(o_miso_oen), 1);
    chk("disarmed busy", int'(o_busy), 0);
    i_cs_n = 1'b1;
    clks(8);
    mo_buf[0] = 8'hA5;
    frame(1);
    chk("armed rx_data", int'(rx_data), 'hA5);
    chk("armed rx_valid", int'(rx_valid), 1);
    $display("armed frame: rx_data=%h rx_valid=%b", rx_data, rx_valid);
    rx_ready = 1'b1;
    clks(2);

    for (int i = 0; i < 4; i++) run_and_check($sformatf("vec%0d", i), vecs[i]);
    clr_pulse();
    chk("clr underrun", int'(o_tx_underrun), 0);

    // Random frames against a frame-level model: byte k of MISO is the k-th queued
    // byte or IDLE_BYTE; a frame of n bytes performs n+1 loads.
    for (int r = 0; r < 6; r++) begin
      rv.n = int'($urandom_range(1, 3));
      rv.ntx = int'($urandom_range(0, 3));
      for (int k = 0; k < 3; k++) begin
        rv.mo[k] = 8'($urandom);
        rv.tx[k] = 8'($urandom);
        rv.miso[k] = (k < rv.ntx) ? rv.tx[k] : 8'hFF;
      end
      rv.pops = (rv.ntx < rv.n + 1) ? rv.ntx : rv.n + 1;
      rv.underrun = (rv.ntx < rv.n + 1);
      run_and_check($sformatf("rand%0d", r), rv);
    end

    // Overrun: consumer stalled across two bytes.
    clr_pulse();
    rx_q.delete();
    rx_ready = 1'b0;
    mo_buf[0] = 8'h55;
    mo_buf[1] = 8'h66;
    frame(2);
    chk("ovr rx_data", int'(rx_data), 'h55);
    chk("ovr rx_valid", int'(rx_valid), 1);
    chk("ovr flag", int'(o_rx_overrun), 1);
    rx_ready = 1'b1;
    clks(1);
    rx_ready = 1'b0;
    chk("ovr drained", int'(rx_valid), 0);
    $display("overrun frame: rx_data=%h ovr=%b", rx_data, o_rx_overrun);
    rx_ready = 1'b1;
    rx_q.delete();
    clr_pulse();

    // Partial frame of 5 bits, then a clean frame.
    fe0 = fe_cnt;
    i_cs_n = 1'b0;
    spi_bits(8'hC0, 5, m);
    clks(HALF);
    i_cs_n = 1'b1;
    clks(8);
    chk("part frame_end", fe_cnt - fe0, 1);
    chk("part frame_err", int'(o_frame_err), 1);
    chk("part no_rx", rx_q.size(), 0);
    chk("part oen", int'(o_miso_oen), 1);
    mo_buf[0] = 8'h81;
    frame(1);
    chk("part next_count", rx_q.size(), 1);
    if (rx_q.size() > 0) chk("part next_byte", int'(rx_q[0]), 'h81);
    $display("partial frame: err=%b next rx_count=%0d", o_frame_err, rx_q.size());
    clr_pulse();
    rx_q.delete();

    // Asynchronous reset in the middle of a byte.
    i_cs_n = 1'b0;
    spi_bits(8'hAA, 3, m);
    chk("mid busy", int'(o_busy), 1);
    chk("mid oen", int'(o_miso_oen), 0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst oen", int'(o_miso_oen), 1);
    chk("arst busy", int'(o_busy), 0);
    chk("arst miso", int'(o_miso), 1);
    chk("arst rx_data", int'(rx_data), 0);
    chk("arst rx_valid", int'(rx_valid), 0);
    i_sclk = 1'b0;
    clks(3);
    reset_n = 1'b1;
    clks(10);
    chk("rearm wait oen", int'(o_miso_oen), 1);
    i_cs_n = 1'b1;
    clks(8);
    mo_buf[0] = 8'h7E;
    frame(1);
    chk("rearm rx_count", rx_q.size(), 1);
    chk("rearm rx_data", int'(rx_data), 'h7E);
    $display("reset recovery: rx_data=%h", rx_data);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
